// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types and constants.
// FSM states, port IDs and alignment masks.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S_RD   = 2'd1,
        V_BEAT = 2'd2,
        V_TAIL = 2'd3
    } state_e;

    typedef enum logic {
        PORT_S = 1'b0,
        PORT_V = 1'b1
    } port_e;

    localparam int VEC_BEATS = 4;

    localparam logic [3:0] S_ALIGN_MASK = 4'h3;
    localparam logic [3:0] V_ALIGN_MASK = 4'hF;

    function automatic logic misaligned(
        input logic [3:0] addr,
        input logic [3:0] mask
    );
        return |(addr & mask);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle between execute stage, data RAM and dmem_arbiter.
// slave = arbiter side, master = requester/RAM side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              s_req_i;
    logic              s_we_i;
    logic [ADDR_W-1:0] s_addr_i;
    logic [31:0]       s_wdata_i;
    logic              s_gnt_o;
    logic              s_rvalid_o;
    logic [31:0]       s_rdata_o;

    logic              v_req_i;
    logic              v_we_i;
    logic [ADDR_W-1:0] v_addr_i;
    logic [127:0]      v_wdata_i;
    logic              v_gnt_o;
    logic              v_done_o;
    logic [127:0]      v_rdata_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    logic              err_o;
    logic              busy_o;

    modport slave (
        input  s_req_i, s_we_i, s_addr_i, s_wdata_i,
        output s_gnt_o, s_rvalid_o, s_rdata_o,
        input  v_req_i, v_we_i, v_addr_i, v_wdata_i,
        output v_gnt_o, v_done_o, v_rdata_o,
        output mem_addr_o, mem_we_o, mem_wdata_o,
        input  mem_rdata_i,
        output err_o, busy_o
    );

    modport master (
        output s_req_i, s_we_i, s_addr_i, s_wdata_i,
        input  s_gnt_o, s_rvalid_o, s_rdata_o,
        output v_req_i, v_we_i, v_addr_i, v_wdata_i,
        input  v_gnt_o, v_done_o, v_rdata_o,
        input  mem_addr_o, mem_we_o, mem_wdata_o,
        output mem_rdata_i,
        input  err_o, busy_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way scalar/vector arbiter with a last-grant pointer.
// RR_EN=0 turns it into fixed priority with scalar first.
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_s_i,
    input  logic req_v_i,
    output logic gnt_s_o,
    output logic gnt_v_o
);

    port_e last_q, last_d;
    logic  pick_v;

    always_comb begin
        pick_v = 1'b0;
        if (req_s_i && req_v_i) begin
            pick_v = RR_EN && (last_q == PORT_S);
        end else if (req_v_i) begin
            pick_v = 1'b1;
        end

        gnt_s_o = en_i && req_s_i && !pick_v;
        gnt_v_o = en_i && req_v_i && pick_v;

        last_d = last_q;
        if (gnt_s_o) begin
            last_d = PORT_S;
        end else if (gnt_v_o) begin
            last_d = PORT_V;
        end
    end

    // Pointing at vector after reset lets scalar win the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= PORT_V;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one 32-bit data RAM between scalar and 128-bit SIMD ports.
// SIMD accesses are split into four word beats on the RAM port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input logic            clk_i,
    input logic            rst_i,
    dmem_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic [127:0]      wdata_q, wdata_d;
    logic [127:0]      rdata_q, rdata_d;
    logic              done_q, done_d;

    logic              arb_en;
    logic              gnt_s;
    logic              gnt_v;
    logic              s_mis;
    logic              v_mis;
    logic [1:0]        slot;
    logic [ADDR_W-1:0] beat_ofs;

    assign arb_en   = (state_q == IDLE) && !rst_i;
    assign s_mis    = misaligned(bus.s_addr_i[3:0], S_ALIGN_MASK);
    assign v_mis    = misaligned(bus.v_addr_i[3:0], V_ALIGN_MASK);
    assign slot     = beat_q - 2'd1;
    assign beat_ofs = {{(ADDR_W-4){1'b0}}, beat_q, 2'b00};

    rr_arb2 #(
        .RR_EN(RR_EN)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (arb_en),
        .req_s_i (bus.s_req_i),
        .req_v_i (bus.v_req_i),
        .gnt_s_o (gnt_s),
        .gnt_v_o (gnt_v)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;

        bus.s_gnt_o     = gnt_s;
        bus.v_gnt_o     = gnt_v;
        bus.s_rvalid_o  = 1'b0;
        bus.s_rdata_o   = '0;
        bus.mem_addr_o  = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_wdata_o = '0;
        bus.err_o       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_s) begin
                    bus.mem_addr_o = bus.s_addr_i;
                    if (s_mis) begin
                        bus.err_o = 1'b1;
                    end else if (bus.s_we_i) begin
                        bus.mem_we_o    = 1'b1;
                        bus.mem_wdata_o = bus.s_wdata_i;
                    end else begin
                        state_d = S_RD;
                    end
                end else if (gnt_v) begin
                    bus.mem_addr_o = bus.v_addr_i;
                    if (v_mis) begin
                        bus.err_o = 1'b1;
                    end else begin
                        bus.mem_we_o    = bus.v_we_i;
                        bus.mem_wdata_o = bus.v_wdata_i[31:0];
                        base_d  = bus.v_addr_i;
                        we_d    = bus.v_we_i;
                        wdata_d = bus.v_wdata_i;
                        beat_d  = 2'd1;
                        state_d = V_BEAT;
                    end
                end
            end
            S_RD: begin
                bus.s_rvalid_o = 1'b1;
                bus.s_rdata_o  = bus.mem_rdata_i;
                state_d        = IDLE;
            end
            V_BEAT: begin
                bus.mem_addr_o  = base_q + beat_ofs;
                bus.mem_we_o    = we_q;
                bus.mem_wdata_o = wdata_q[32*beat_q +: 32];
                if (!we_q) begin
                    rdata_d[32*slot +: 32] = bus.mem_rdata_i;
                end
                beat_d = beat_q + 2'd1;
                // Writes finish with the last beat, so done lands in V_TAIL.
                if (beat_q == 2'(VEC_BEATS - 1)) begin
                    done_d  = we_q;
                    state_d = V_TAIL;
                end
            end
            V_TAIL: begin
                if (!we_q) begin
                    rdata_d[96 +: 32] = bus.mem_rdata_i;
                    done_d            = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Nothing reaches the RAM or requesters while reset is held.
        if (rst_i) begin
            bus.s_rvalid_o  = 1'b0;
            bus.s_rdata_o   = '0;
            bus.mem_addr_o  = '0;
            bus.mem_we_o    = 1'b0;
            bus.mem_wdata_o = '0;
            bus.err_o       = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    assign bus.v_done_o  = done_q;
    assign bus.v_rdata_o = rdata_q;
    assign bus.busy_o    = (state_q != IDLE);

endmodule
